hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the stall performance counter width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs1_addr, id_rs2_addr  in  5 each  ID-stage source registers.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  source is actually read.
REQ-006 ex_rd, ex_reg_write, ex_mem_read, ex_csr_hit  in  5/1/1/1  ID/EX-latched instruction now in EX.
REQ-007 exmem_rd, exmem_reg_write, exmem_mem_read, exmem_csr_hit  in  5/1/1/1  EX/MEM instruction.
REQ-008 ex_is_muldiv  in  1  EX holds a multi-cycle mul/div.
REQ-009 muldiv_done  in  1  one-cycle pulse from the mul/div unit; result valid.
REQ-010 ex_redirect  in  1  taken branch/jump resolved in EX.
REQ-011 pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble  out  1 each  pipeline register controls.
REQ-012 muldiv_start  out  1  one-cycle start pulse to the mul/div unit.
REQ-013 stall_count  out  CNT_W  saturating count of stall cycles since reset.

Function
REQ-014 The block SHALL implement FSM states RUN, LU_WAIT and MD_BUSY; all outputs SHALL be combinational from state plus current inputs.
REQ-015 Slow producer SHALL mean reg_write && rd!=0 && (mem_read || csr_hit); match SHALL require id_uses_rsN && rsN==rd.
REQ-016 In RUN, a match against a slow EX producer SHALL assert pc_stall, ifid_stall and idex_flush, and SHALL move to LU_WAIT.
REQ-017 In RUN, a match against a slow EX/MEM producer only SHALL assert the same three signals for exactly that cycle and SHALL stay in RUN.
REQ-018 LU_WAIT SHALL assert pc_stall, ifid_stall and idex_flush for one cycle, then return to RUN; producers are then at MEM2 or later and are forwarded from WB, so total stall is 2 cycles (EX case) or 1 cycle (EX/MEM case).
REQ-019 In RUN with ex_is_muldiv=1, the block SHALL pulse muldiv_start, assert pc_stall, ifid_stall, idex_stall and exmem_bubble, and move to MD_BUSY.
REQ-020 MD_BUSY SHALL hold those four stall signals while muldiv_done=0, and SHALL NOT re-pulse muldiv_start.
REQ-021 In the cycle muldiv_done=1, MD_BUSY SHALL deassert all stalls and return to RUN, so EX advances that edge.
REQ-022 Priority SHALL be ex_redirect > muldiv > load/CSR-use.
REQ-023 ex_redirect in RUN or LU_WAIT SHALL assert ifid_flush and idex_flush, suppress all stalls, and force the next state to RUN.
REQ-024 ex_redirect SHALL be ignored in MD_BUSY.
REQ-025 Simultaneous EX and EX/MEM matches SHALL be treated as the EX case.
REQ-026 Register x0 SHALL never cause a stall.
REQ-027 stall_count SHALL increment in every cycle in which pc_stall=1, and SHALL saturate at all-ones without wrapping.

Reset
REQ-028 While rst=1, all outputs except stall_count SHALL be 0.
REQ-029 On the first edge with rst=1, state SHALL become RUN and stall_count SHALL become 0, including mid-LU_WAIT or mid-MD_BUSY.
REQ-030 A muldiv_done arriving during reset SHALL be ignored.

Structure
REQ-031 FSM state encoding and the mul/div start/done handshake definition SHALL live in the shared core package.
REQ-032 Hazard match logic SHALL be one sub-module, hazard_match, instantiated once per source register; the FSM and counter SHALL stay in hazard_ctrl.

Verification
REQ-033 Scenario, EX-load stall: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID rs1=5 -> pc_stall=1 for exactly 2 cycles, idex_flush=1 both cycles, stall_count=2.
REQ-034 Scenario, EX/MEM CSR stall: exmem_csr_hit=1, exmem_rd=7, ID rs2=7 -> exactly 1 stall cycle; the same with rd=0 -> no stall.
REQ-035 Scenario, redirect abort: redirect during LU_WAIT -> ifid_flush=1, idex_flush=1, pc_stall=0 that cycle, state RUN next cycle.
REQ-036 Scenario, mul/div handshake: ex_is_muldiv=1, muldiv_done after 5 cycles -> one muldiv_start pulse, stalls asserted 5 cycles, released in the done cycle.
REQ-037 Scenario, reset mid-MD_BUSY: rst=1 for 1 cycle in MD_BUSY -> outputs 0, state RUN, stall_count=0, and a later muldiv_done is ignored.
REQ-038 Scenario, saturation: CNT_W=4 with 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions: hazard FSM encoding and mul/div handshake.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LU_WAIT = 2'd1,
        ST_MD_BUSY = 2'd2
    } hz_state_e;

    // Start fires only from RUN; done is honoured only while busy.
    function automatic logic md_fire(hz_state_e st, logic is_md);
        return (st == ST_RUN) && is_md;
    endfunction

    function automatic logic md_release(hz_state_e st, logic done);
        return (st == ST_MD_BUSY) && done;
    endfunction

    function automatic logic slow_prod(logic rw, logic [4:0] rd,
                                       logic mr, logic ch);
        return rw && (rd != 5'd0) && (mr || ch);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source-register match against slow producers in EX and EX/MEM.
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       uses_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_rw_i,
    input  logic       ex_mr_i,
    input  logic       ex_csr_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_rw_i,
    input  logic       mem_mr_i,
    input  logic       mem_csr_i,
    output logic       ex_hit_o,
    output logic       mem_hit_o
);

    assign ex_hit_o = uses_i && (rs_i == ex_rd_i)
                   && slow_prod(ex_rw_i, ex_rd_i, ex_mr_i, ex_csr_i);

    assign mem_hit_o = uses_i && (rs_i == mem_rd_i)
                    && slow_prod(mem_rw_i, mem_rd_i, mem_mr_i, mem_csr_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load/CSR-use stalls, mul/div hold, redirects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_csr_hit,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_reg_write,
    input  logic             exmem_mem_read,
    input  logic             exmem_csr_hit,
    input  logic             ex_is_muldiv,
    input  logic             muldiv_done,
    input  logic             ex_redirect,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             muldiv_start,
    output logic [CNT_W-1:0] stall_count
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs1_ex, rs1_mem, rs2_ex, rs2_mem;
    logic             ex_hit, mem_hit;

    hazard_match u_rs1 (
        .rs_i      (id_rs1_addr),
        .uses_i    (id_uses_rs1),
        .ex_rd_i   (ex_rd),
        .ex_rw_i   (ex_reg_write),
        .ex_mr_i   (ex_mem_read),
        .ex_csr_i  (ex_csr_hit),
        .mem_rd_i  (exmem_rd),
        .mem_rw_i  (exmem_reg_write),
        .mem_mr_i  (exmem_mem_read),
        .mem_csr_i (exmem_csr_hit),
        .ex_hit_o  (rs1_ex),
        .mem_hit_o (rs1_mem)
    );

    hazard_match u_rs2 (
        .rs_i      (id_rs2_addr),
        .uses_i    (id_uses_rs2),
        .ex_rd_i   (ex_rd),
        .ex_rw_i   (ex_reg_write),
        .ex_mr_i   (ex_mem_read),
        .ex_csr_i  (ex_csr_hit),
        .mem_rd_i  (exmem_rd),
        .mem_rw_i  (exmem_reg_write),
        .mem_mr_i  (exmem_mem_read),
        .mem_csr_i (exmem_csr_hit),
        .ex_hit_o  (rs2_ex),
        .mem_hit_o (rs2_mem)
    );

    assign ex_hit  = rs1_ex || rs2_ex;
    assign mem_hit = rs1_mem || rs2_mem;

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_start = 1'b0;
        state_d      = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (md_fire(state_q, ex_is_muldiv)) begin
                    muldiv_start = 1'b1;
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    state_d      = ST_MD_BUSY;
                end else if (ex_hit || mem_hit) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    // Only an EX producer needs the second bubble.
                    if (ex_hit) state_d = ST_LU_WAIT;
                end
            end
            ST_LU_WAIT: begin
                state_d = ST_RUN;
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                if (md_release(state_q, muldiv_done)) begin
                    state_d = ST_RUN;
                end else begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            ifid_flush   = 1'b0;
            idex_stall   = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            muldiv_start = 1'b0;
            state_d      = ST_RUN;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus random traffic against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd, exmem_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_reg_write, ex_mem_read, ex_csr_hit;
    logic       exmem_reg_write, exmem_mem_read, exmem_csr_hit;
    logic       ex_is_muldiv, muldiv_done, ex_redirect;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall;
    logic       idex_flush, exmem_bubble, muldiv_start;
    logic [15:0] stall_count;
    logic       p4, fs4, ff4, is4, if4, eb4, ms4;
    logic [3:0] stall_count4;

    int n_chk = 0;
    int n_err = 0;

    bit m_lu, m_md;
    int m_cnt, m_cnt4;

    localparam logic [6:0] E_STALL3 = 7'b1100100;
    localparam logic [6:0] E_STALL4 = 7'b1101010;
    localparam logic [6:0] E_START  = 7'b1101011;
    localparam logic [6:0] E_FLUSH  = 7'b0010100;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_csr_hit(ex_csr_hit),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_csr_hit(exmem_csr_hit),
        .ex_is_muldiv(ex_is_muldiv), .muldiv_done(muldiv_done),
        .ex_redirect(ex_redirect),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_stall(idex_stall),
        .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
        .muldiv_start(muldiv_start), .stall_count(stall_count)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_csr_hit(ex_csr_hit),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_csr_hit(exmem_csr_hit),
        .ex_is_muldiv(ex_is_muldiv), .muldiv_done(muldiv_done),
        .ex_redirect(ex_redirect),
        .pc_stall(p4), .ifid_stall(fs4),
        .ifid_flush(ff4), .idex_stall(is4),
        .idex_flush(if4), .exmem_bubble(eb4),
        .muldiv_start(ms4), .stall_count(stall_count4)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic bit slow(bit rw, logic [4:0] rd, bit mr, bit ch);
        return rw && (rd != 0) && (mr || ch);
    endfunction

    function automatic bit reads(logic [4:0] rd);
        return (id_uses_rs1 && id_rs1_addr == rd)
            || (id_uses_rs2 && id_rs2_addr == rd);
    endfunction

    task automatic idle();
        id_rs1_addr = 0; id_rs2_addr = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_csr_hit = 0;
        exmem_rd = 0; exmem_reg_write = 0;
        exmem_mem_read = 0; exmem_csr_hit = 0;
        ex_is_muldiv = 0; muldiv_done = 0; ex_redirect = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model.
    task automatic cycle();
        logic [6:0] e;
        bit ex_m, mem_m;
        @(negedge clk);
        ex_m  = slow(ex_reg_write, ex_rd, ex_mem_read, ex_csr_hit)
             && reads(ex_rd);
        mem_m = slow(exmem_reg_write, exmem_rd, exmem_mem_read,
                     exmem_csr_hit) && reads(exmem_rd);
        e = '0;
        if (rst) begin
            m_lu = 0; m_md = 0;
        end else if (m_md) begin
            if (!muldiv_done) e = E_STALL4;
            else m_md = 0;
        end else if (ex_redirect) begin
            e = E_FLUSH; m_lu = 0;
        end else if (m_lu) begin
            e = E_STALL3; m_lu = 0;
        end else if (ex_is_muldiv) begin
            e = E_START; m_md = 1;
        end else if (ex_m) begin
            e = E_STALL3; m_lu = 1;
        end else if (mem_m) begin
            e = E_STALL3;
        end
        check("ctl", {25'd0, pc_stall, ifid_stall, ifid_flush, idex_stall,
                      idex_flush, exmem_bubble, muldiv_start}, {25'd0, e});
        check("cnt", {16'd0, stall_count}, m_cnt);
        check("cnt4", {28'd0, stall_count4}, m_cnt4);
        if (rst) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (e[6]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        m_lu = 0; m_md = 0; m_cnt = 0; m_cnt4 = 0;
        @(posedge clk);
        #1;
        do_reset();

        // EX load-use: two stall cycles
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5;
        id_rs1_addr = 5; id_uses_rs1 = 1;
        cycle();
        ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
        cycle();
        idle();
        cycle();
        check("ld_total", {16'd0, stall_count}, 2);

        // EX/MEM CSR-use: one stall; rd=0 never stalls
        do_reset();
        exmem_reg_write = 1; exmem_csr_hit = 1; exmem_rd = 7;
        id_rs2_addr = 7; id_uses_rs2 = 1;
        cycle();
        idle();
        cycle();
        check("csr_total", {16'd0, stall_count}, 1);
        do_reset();
        exmem_reg_write = 1; exmem_csr_hit = 1; exmem_rd = 0;
        id_rs2_addr = 0; id_uses_rs2 = 1;
        cycle();
        check("x0_total", {16'd0, stall_count}, 0);

        // Redirect aborts LU_WAIT
        do_reset();
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 9;
        id_rs1_addr = 9; id_uses_rs1 = 1;
        cycle();
        idle();
        ex_redirect = 1;
        cycle();
        idle();
        cycle();

        // Mul/div handshake: done on the 6th cycle, 5 stall cycles
        do_reset();
        ex_is_muldiv = 1;
        repeat (5) cycle();
        muldiv_done = 1;
        cycle();
        idle();
        cycle();
        check("md_total", {16'd0, stall_count}, 5);

        // Reset in MD_BUSY; done during and after reset ignored
        do_reset();
        ex_is_muldiv = 1;
        repeat (2) cycle();
        rst = 1; muldiv_done = 1;
        cycle();
        rst = 0; ex_is_muldiv = 0;
        cycle();
        muldiv_done = 0;
        cycle();
        check("rst_total", {16'd0, stall_count}, 0);

        // Saturation of the 4-bit counter over 20 stalls
        do_reset();
        ex_is_muldiv = 1;
        repeat (20) cycle();
        muldiv_done = 1;
        cycle();
        idle();
        cycle();
        check("sat4", {28'd0, stall_count4}, 15);
        check("sat16", {16'd0, stall_count}, 20);

        do_reset();
        repeat (3000) begin
            rst             = ($urandom_range(0, 59) == 0);
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom);
            id_uses_rs2     = 1'($urandom);
            ex_rd           = 5'($urandom_range(0, 3));
            ex_reg_write    = 1'($urandom);
            ex_mem_read     = 1'($urandom);
            ex_csr_hit      = ($urandom_range(0, 3) == 0);
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom);
            exmem_mem_read  = 1'($urandom);
            exmem_csr_hit   = ($urandom_range(0, 3) == 0);
            ex_is_muldiv    = ($urandom_range(0, 9) == 0);
            muldiv_done     = ($urandom_range(0, 3) == 0);
            ex_redirect     = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
